// File: rtl/fifo_param_if.sv
// ---------------------------------------------------------------------------
// fifo_param_if
// Bundles the producer/consumer handshake and status signals of fifo_param.
//
// Signals:
//   wr_en        write request (producer -> FIFO)
//   din          write data   (producer -> FIFO)
//   rd_en        read request / FWFT pop (consumer -> FIFO)
//   dout         read data (FIFO -> consumer)
//   count        occupancy 0..DEPTH
//   full, empty, almost_full, almost_empty   decodes of the registered count
//   overflow, underflow                      one-cycle registered error pulses
//
// Modports:
//   master  - the side that drives requests (producer/consumer, testbench)
//   slave   - the FIFO itself
// ---------------------------------------------------------------------------
interface fifo_param_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             wr_en;
  logic [WIDTH-1:0] din;
  logic             rd_en;
  logic [WIDTH-1:0] dout;
  logic [CW-1:0]    count;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic             overflow;
  logic             underflow;

  modport master (
    output wr_en, din, rd_en,
    input  dout, count, full, empty, almost_full, almost_empty,
           overflow, underflow
  );

  modport slave (
    input  wr_en, din, rd_en,
    output dout, count, full, empty, almost_full, almost_empty,
           overflow, underflow
  );
endinterface

// File: rtl/fifo_param.sv
// ---------------------------------------------------------------------------
// fifo_param
// Parametrised single-clock FIFO with standard (registered) or
// first-word-fall-through read, almost-full/almost-empty thresholds and
// registered overflow/underflow pulses.
//
// Ports:
//   clk  - clock, all state changes on the rising edge
//   rst  - synchronous active-high reset (priority over wr_en/rd_en)
//   bus  - fifo_param_if.slave: wr_en/din/rd_en in; dout, count, full,
//          empty, almost_full, almost_empty, overflow, underflow out
//
// Parameters: WIDTH, DEPTH (power of two, >=4), AF_LEVEL, AE_LEVEL, FWFT.
// ---------------------------------------------------------------------------
module fifo_param #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  parameter int FWFT     = 0
) (
  input  logic          clk,
  input  logic          rst,
  fifo_param_if.slave   bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C   = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C   = CW'(AE_LEVEL);
  localparam logic [CW-1:0] ONE_C  = CW'(1);
  localparam logic [AW-1:0] PINC_C = AW'(1);

  // Storage: no reset so it maps onto block RAM.
  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] dout_q;
  logic             overflow_q, underflow_q;

  logic             full_w, empty_w;
  logic             wr_acc, rd_acc;

  // Flags come from the registered count only.
  assign full_w  = (count_q == FULL_C);
  assign empty_w = (count_q == '0);

  // Full/empty gating alone resolves every simultaneous-request case:
  // at full the read wins, at empty the write wins, otherwise both go.
  assign wr_acc = bus.wr_en && !full_w;
  assign rd_acc = bus.rd_en && !empty_w;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + PINC_C;
    if (rd_acc) rd_ptr_d = rd_ptr_q + PINC_C;
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + ONE_C;
      2'b01:   count_d = count_q - ONE_C;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= bus.wr_en && full_w;
      underflow_q <= bus.rd_en && empty_w;
    end
  end

  // Reset blocks the write so a reset cycle never stores data.
  always_ff @(posedge clk) begin
    if (wr_acc && !rst) begin
      mem[wr_ptr_q] <= bus.din;
    end
  end

  generate
    if (FWFT == 0) begin : g_std
      // Registered read: dout updates only on an accepted read.
      always_ff @(posedge clk) begin
        if (rst) begin
          dout_q <= '0;
        end else if (rd_acc) begin
          dout_q <= mem[rd_ptr_q];
        end
      end
    end else begin : g_fwft
      // dout is pre-fetched from the next head address every cycle so it
      // always shows the head word (or 0 when empty) with a registered
      // RAM read. When the word being written this cycle becomes the head
      // (the FIFO is, or drains to, empty apart from it), the RAM does not
      // hold it yet, so din is forwarded instead.
      always_ff @(posedge clk) begin
        if (rst) begin
          dout_q <= '0;
        end else if (count_d == '0) begin
          dout_q <= '0;
        end else if (wr_acc && (wr_ptr_q == rd_ptr_d)) begin
          dout_q <= bus.din;
        end else begin
          dout_q <= mem[rd_ptr_d];
        end
      end
    end
  endgenerate

  assign bus.dout         = dout_q;
  assign bus.count        = count_q;
  assign bus.full         = full_w;
  assign bus.empty        = empty_w;
  assign bus.almost_full  = (count_q >= AF_C);
  assign bus.almost_empty = (count_q <= AE_C);
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;
endmodule

// File: tb/tb_fifo_param.sv
// ---------------------------------------------------------------------------
// tb_fifo_param
// Drives identical stimulus into a standard-read and an FWFT instance of
// fifo_param (DEPTH=16, WIDTH=8) and compares every output after each edge
// against a queue-based reference model.
// ---------------------------------------------------------------------------
module tb_fifo_param;
  localparam int W = 8;
  localparam int D = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         wr_en = 1'b0;
  logic         rd_en = 1'b0;
  logic [W-1:0] din = '0;

  always #5 clk = ~clk;

  fifo_param_if #(.WIDTH(W), .DEPTH(D)) bus0 ();
  fifo_param_if #(.WIDTH(W), .DEPTH(D)) bus1 ();

  assign bus0.wr_en = wr_en;
  assign bus0.rd_en = rd_en;
  assign bus0.din   = din;
  assign bus1.wr_en = wr_en;
  assign bus1.rd_en = rd_en;
  assign bus1.din   = din;

  fifo_param #(.WIDTH(W), .DEPTH(D), .AF_LEVEL(D-2), .AE_LEVEL(2), .FWFT(0))
    u_std (.clk(clk), .rst(rst), .bus(bus0));
  fifo_param #(.WIDTH(W), .DEPTH(D), .AF_LEVEL(D-2), .AE_LEVEL(2), .FWFT(1))
    u_fwft (.clk(clk), .rst(rst), .bus(bus1));

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;

  // Reference model: plain queue of stored words.
  logic [W-1:0] q[$];
  logic [W-1:0] m_dout_std = '0;
  bit           m_ovf = 1'b0;
  bit           m_unf = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic void model_step(input bit w, input bit r,
                                     input logic [W-1:0] d, input bit rs);
    int sz;
    if (rs) begin
      q.delete();
      m_dout_std = '0;
      m_ovf = 1'b0;
      m_unf = 1'b0;
      return;
    end
    sz = q.size();
    m_ovf = w && (sz == D);
    m_unf = r && (sz == 0);
    if (r && sz != 0) m_dout_std = q.pop_front();
    if (w && sz != D) q.push_back(d);
  endfunction

  task automatic check_all();
    int sz;
    logic [W-1:0] exp_fwft;
    sz = q.size();
    exp_fwft = (sz != 0) ? q[0] : '0;
    check_eq("count",        32'(bus0.count),        32'(sz));
    check_eq("count_fwft",   32'(bus1.count),        32'(sz));
    check_eq("full",         32'(bus0.full),         32'(sz == D));
    check_eq("empty",        32'(bus0.empty),        32'(sz == 0));
    check_eq("almost_full",  32'(bus0.almost_full),  32'(sz >= D-2));
    check_eq("almost_empty", 32'(bus0.almost_empty), 32'(sz <= 2));
    check_eq("overflow",     32'(bus0.overflow),     32'(m_ovf));
    check_eq("underflow",    32'(bus0.underflow),    32'(m_unf));
    check_eq("ovf_fwft",     32'(bus1.overflow),     32'(m_ovf));
    check_eq("unf_fwft",     32'(bus1.underflow),    32'(m_unf));
    check_eq("dout_std",     32'(bus0.dout),         32'(m_dout_std));
    check_eq("dout_fwft",    32'(bus1.dout),         32'(exp_fwft));
  endtask

  // One transaction: drive, clock, update model, check, report.
  task automatic cycle(input bit w, input bit r, input logic [W-1:0] d,
                       input bit rs);
    wr_en = w;
    rd_en = r;
    din   = d;
    rst   = rs;
    @(posedge clk);
    model_step(w, r, d, rs);
    #1;
    cyc++;
    check_all();
    $display("[TB] cyc=%0d rst=%0b wr=%0b rd=%0b din=%02h count=%0d dout_std=%02h dout_fwft=%02h ovf=%0b unf=%0b",
             cyc, rs, w, r, d, bus0.count, bus0.dout, bus1.dout,
             bus0.overflow, bus0.underflow);
  endtask

  initial begin
    int wbias;
    int rbias;
    // Reset then idle
    cycle(1'b0, 1'b0, 8'h00, 1'b1);
    cycle(1'b0, 1'b0, 8'h00, 1'b0);
    check_eq("reset_count", 32'(bus0.count), 32'd0);

    // Fill 0x01..0x10, then one overflowing write
    for (int i = 1; i <= D; i++) cycle(1'b1, 1'b0, W'(i), 1'b0);
    check_eq("fill_full", 32'(bus0.full), 32'd1);
    cycle(1'b1, 1'b0, 8'hEE, 1'b0);
    cycle(1'b0, 1'b0, 8'h00, 1'b0);
    check_eq("ovf_count", 32'(bus0.count), 32'd16);

    // Drain
    for (int i = 0; i < D; i++) cycle(1'b0, 1'b1, 8'h00, 1'b0);
    check_eq("drain_last", 32'(bus0.dout), 32'h10);

    // Wrap-around
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, W'(8'h30 + i), 1'b0);
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 8'h00, 1'b0);
    for (int i = 0; i < 12; i++) cycle(1'b1, 1'b0, W'(8'hA0 + i), 1'b0);
    for (int i = 0; i < 12; i++) cycle(1'b0, 1'b1, 8'h00, 1'b0);

    // Simultaneous at full, then at empty
    for (int i = 0; i < D; i++) cycle(1'b1, 1'b0, W'($urandom), 1'b0);
    cycle(1'b1, 1'b1, 8'h77, 1'b0);
    check_eq("sim_full_cnt", 32'(bus0.count), 32'd15);
    for (int i = 0; i < 15; i++) cycle(1'b0, 1'b1, 8'h00, 1'b0);
    cycle(1'b1, 1'b1, 8'h66, 1'b0);
    check_eq("sim_empty_cnt", 32'(bus0.count), 32'd1);

    // Hold both at count=5 for 20 cycles
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, W'($urandom), 1'b0);
    for (int i = 0; i < 20; i++) cycle(1'b1, 1'b1, W'($urandom), 1'b0);
    check_eq("hold5_cnt", 32'(bus0.count), 32'd5);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 8'h00, 1'b0);

    // FWFT single word, pop, read on empty
    cycle(1'b1, 1'b0, 8'h55, 1'b0);
    check_eq("fwft_55", 32'(bus1.dout), 32'h55);
    cycle(1'b0, 1'b0, 8'h00, 1'b0);
    cycle(1'b0, 1'b1, 8'h00, 1'b0);
    cycle(1'b0, 1'b1, 8'h00, 1'b0);
    cycle(1'b0, 1'b0, 8'h00, 1'b0);

    // Reset mid-stream at count=9 together with wr_en and rd_en
    for (int i = 0; i < 9; i++) cycle(1'b1, 1'b0, W'(8'hC0 + i), 1'b0);
    cycle(1'b1, 1'b1, 8'hDD, 1'b1);
    check_eq("rst_mid_cnt", 32'(bus0.count), 32'd0);
    cycle(1'b0, 1'b0, 8'h00, 1'b0);
    cycle(1'b0, 1'b1, 8'h00, 1'b0);

    // Randomized traffic with drifting bias to visit full and empty
    for (int blk = 0; blk < 8; blk++) begin
      wbias = (blk % 2 == 0) ? 75 : 30;
      rbias = (blk % 2 == 0) ? 30 : 75;
      for (int i = 0; i < 50; i++) begin
        cycle($urandom_range(0, 99) < wbias, $urandom_range(0, 99) < rbias,
              W'($urandom), $urandom_range(0, 199) == 0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
